// File: rtl/obs_cmp_pkg.sv
// Shared types and constants for the dual-copy observation trace checker.
//   state_e         : checker phase (RUN, DRAIN, DONE)
//   mismatch_kind_e : verdict encoding reported on mismatch_kind_o
//   CNT_W           : width of the compared-pair counter and mismatch index
package obs_cmp_pkg;

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      VALUE    = 2'd1,
      LENGTH   = 2'd2,
      OVERFLOW = 2'd3
   } mismatch_kind_e;

endpackage

// File: rtl/obs_fifo.sv
// Per-copy observation buffer: registered storage, no write-to-read bypass.
//   clk_i, rst_ni : clock, async active-low reset (clears pointers only)
//   push_i/data_i : write request and word; ignored when full unless popping
//   pop_i         : read request; ignored when empty
//   rdata_o       : head word (valid when !empty_o)
//   empty_o/full_o: occupancy flags decoded from the pointers
module obs_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              empty_o,
   output logic              full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   // Extra wrap bit distinguishes full from empty when indices coincide.
   assign empty_o   = (r_wr_ptr == r_rd_ptr);
   assign full_o    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_pop  = pop_i && !empty_o;
   // A same-cycle pop frees the slot, so a push to a full buffer is accepted.
   assign w_do_push = push_i && (!full_o || w_do_pop);
   assign rdata_o   = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/obs_trace_compare.sv
// In-order comparison of two CPU-copy observation traces with a sticky verdict.
//   clk_i, rst_ni          : clock, async active-low reset
//   enable_k_i, obs_k_*    : per-copy fetch enable and observation stream
//   finished_i             : run-complete flag (sticky upstream)
//   done_o                 : verdict final, sticky until reset
//   mismatch_o / _kind_o   : verdict (kind: 0 none, 1 value, 2 length, 3 overflow)
//   mismatch_idx_o         : first differing pair index, or pairs compared
//   compared_count_o       : equal pairs compared, saturating
module obs_trace_compare
   import obs_cmp_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_1_i,
   input  logic              enable_2_i,
   input  logic              finished_i,
   input  logic              obs_1_valid_i,
   input  logic [DATA_W-1:0] obs_1_data_i,
   input  logic              obs_2_valid_i,
   input  logic [DATA_W-1:0] obs_2_data_i,
   output logic              done_o,
   output logic              mismatch_o,
   output logic [1:0]        mismatch_kind_o,
   output logic [CNT_W-1:0]  mismatch_idx_o,
   output logic [CNT_W-1:0]  compared_count_o
);

   state_e            r_state;
   mismatch_kind_e    r_kind;
   logic              r_done;
   logic              r_mismatch;
   logic [CNT_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_count;

   logic              w_push_1, w_push_2;
   logic [DATA_W-1:0] w_rdata_1, w_rdata_2;
   logic              w_empty_1, w_empty_2;
   logic              w_full_1, w_full_2;
   logic              w_cmp;
   logic              w_val_mm;
   logic              w_ovf;

   assign w_push_1 = obs_1_valid_i && enable_1_i && (r_state == RUN);
   assign w_push_2 = obs_2_valid_i && enable_2_i && (r_state == RUN);
   // Compare pops both heads together, so at most one pair per cycle.
   assign w_cmp    = !w_empty_1 && !w_empty_2 && (r_state != DONE);
   assign w_val_mm = w_cmp && (w_rdata_1 != w_rdata_2);
   assign w_ovf    = (w_push_1 && w_full_1 && !w_cmp) ||
                     (w_push_2 && w_full_2 && !w_cmp);

   obs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push_1),
      .data_i  (obs_1_data_i),
      .pop_i   (w_cmp),
      .rdata_o (w_rdata_1),
      .empty_o (w_empty_1),
      .full_o  (w_full_1)
   );

   obs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push_2),
      .data_i  (obs_2_data_i),
      .pop_i   (w_cmp),
      .rdata_o (w_rdata_2),
      .empty_o (w_empty_2),
      .full_o  (w_full_2)
   );

   // Phase control, pair counter and verdict registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= RUN;
         r_kind     <= NONE;
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         r_idx      <= '0;
         r_count    <= '0;
      end else begin
         case (r_state)
            RUN, DRAIN: begin
               if (w_val_mm) begin
                  r_state    <= DONE;
                  r_kind     <= VALUE;
                  r_idx      <= r_count;
                  r_done     <= 1'b1;
                  r_mismatch <= 1'b1;
               end else if (w_ovf) begin
                  r_state    <= DONE;
                  r_kind     <= OVERFLOW;
                  r_idx      <= r_count;
                  r_done     <= 1'b1;
                  r_mismatch <= 1'b1;
               end else if (w_cmp) begin
                  if (r_count != '1) r_count <= r_count + CNT_W'(1);
                  if (r_state == RUN && finished_i) r_state <= DRAIN;
               end else if (r_state == RUN) begin
                  if (finished_i) r_state <= DRAIN;
               end else begin
                  // Draining with nothing to pair: settle the verdict.
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  if (!(w_empty_1 && w_empty_2)) begin
                     r_kind     <= LENGTH;
                     r_idx      <= r_count;
                     r_mismatch <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign done_o           = r_done;
   assign mismatch_o       = r_mismatch;
   assign mismatch_kind_o  = r_kind;
   assign mismatch_idx_o   = r_idx;
   assign compared_count_o = r_count;

endmodule

// File: tb/tb_obs_trace_compare.sv
// Randomized and directed bench for obs_trace_compare against a queue-based trace model.
module tb_obs_trace_compare;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              enable_1_i, enable_2_i, finished_i;
   logic              obs_1_valid_i, obs_2_valid_i;
   logic [DATA_W-1:0] obs_1_data_i, obs_2_data_i;
   logic              done_o, mismatch_o;
   logic [1:0]        mismatch_kind_o;
   logic [31:0]       mismatch_idx_o, compared_count_o;

   obs_trace_compare #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .enable_1_i       (enable_1_i),
      .enable_2_i       (enable_2_i),
      .finished_i       (finished_i),
      .obs_1_valid_i    (obs_1_valid_i),
      .obs_1_data_i     (obs_1_data_i),
      .obs_2_valid_i    (obs_2_valid_i),
      .obs_2_data_i     (obs_2_data_i),
      .done_o           (done_o),
      .mismatch_o       (mismatch_o),
      .mismatch_kind_o  (mismatch_kind_o),
      .mismatch_idx_o   (mismatch_idx_o),
      .compared_count_o (compared_count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Trace model: two queues of pending words plus the verdict the checker should hold.
   typedef enum int {M_RUN, M_DRAIN, M_DONE} mphase_t;
   logic [63:0] q1[$];
   logic [63:0] q2[$];
   mphase_t     m_ph;
   int unsigned m_kind;
   logic [31:0] m_idx, m_cnt;
   bit          fin_r;

   task automatic model_reset();
      q1.delete(); q2.delete();
      m_ph = M_RUN; m_kind = 0; m_idx = 0; m_cnt = 0;
   endtask

   task automatic model_finish(input int unsigned kind);
      m_ph   = M_DONE;
      m_kind = kind;
      if (kind != 0) m_idx = m_cnt;
   endtask

   task automatic model_step(input bit v1, input logic [63:0] d1, input bit v2,
                             input logic [63:0] d2, input bit e1, input bit e2, input bit fin);
      bit p1, p2, pair;
      if (m_ph == M_DONE) return;
      p1   = v1 && e1 && (m_ph == M_RUN);
      p2   = v2 && e2 && (m_ph == M_RUN);
      pair = (q1.size() > 0) && (q2.size() > 0);
      if (pair && q1[0] != q2[0]) begin
         model_finish(1);
      end else if ((p1 && !pair && q1.size() == DEPTH) || (p2 && !pair && q2.size() == DEPTH)) begin
         model_finish(3);
      end else begin
         if (pair) begin
            void'(q1.pop_front()); void'(q2.pop_front());
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
         end
         if (m_ph == M_RUN) begin
            if (p1) q1.push_back(d1);
            if (p2) q2.push_back(d2);
            if (fin) m_ph = M_DRAIN;
         end else if (!pair) begin
            model_finish((q1.size() == 0 && q2.size() == 0) ? 0 : 2);
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".done"},  64'(done_o),           64'(m_ph == M_DONE));
      chk({tag, ".mm"},    64'(mismatch_o),       64'(m_kind != 0));
      chk({tag, ".kind"},  64'(mismatch_kind_o),  64'(m_kind));
      chk({tag, ".idx"},   64'(mismatch_idx_o),   64'(m_idx));
      chk({tag, ".count"}, 64'(compared_count_o), 64'(m_cnt));
   endtask

   // One clock: drive on the falling edge, model the rising edge, sample just after it.
   task automatic cycle(input bit v1, input logic [63:0] d1, input bit v2,
                        input logic [63:0] d2, input bit e1, input bit e2);
      @(negedge clk);
      obs_1_valid_i = v1; obs_1_data_i = d1;
      obs_2_valid_i = v2; obs_2_data_i = d2;
      enable_1_i = e1; enable_2_i = e2; finished_i = fin_r;
      model_step(v1, d1, v2, d2, e1, e2, fin_r);
      @(posedge clk);
      #1;
      check_all("cyc");
   endtask

   task automatic do_reset();
      obs_1_valid_i = 0; obs_2_valid_i = 0; obs_1_data_i = 0; obs_2_data_i = 0;
      enable_1_i = 0; enable_2_i = 0; fin_r = 0; finished_i = 0;
      rst_ni = 0;
      #1;
      model_reset();
      chk("rst.done",  64'(done_o), 0);
      chk("rst.mm",    64'(mismatch_o), 0);
      chk("rst.kind",  64'(mismatch_kind_o), 0);
      chk("rst.idx",   64'(mismatch_idx_o), 0);
      chk("rst.count", 64'(compared_count_o), 0);
      @(negedge clk);
      rst_ni = 1;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && m_ph != M_DONE; i++) cycle(0, 0, 0, 0, 1, 1);
      chk("done_reached", 64'(done_o), 1);
   endtask

   logic [63:0] words[$];

   initial begin
      rst_ni = 1;
      do_reset();

      // Identical short traces pass.
      cycle(1, 64'h10, 1, 64'h10, 1, 1);
      cycle(1, 64'h20, 1, 64'h20, 1, 1);
      cycle(1, 64'h30, 1, 64'h30, 1, 1);
      fin_r = 1;
      wait_done(10);
      chk("pass.mm", 64'(mismatch_o), 0);
      chk("pass.count", 64'(compared_count_o), 3);

      // Value mismatch on the second pair; third pair never counted.
      do_reset();
      cycle(1, 64'h10, 1, 64'h10, 1, 1);
      cycle(1, 64'h20, 1, 64'h24, 1, 1);
      cycle(1, 64'h30, 1, 64'h30, 1, 1);
      chk("val.done", 64'(done_o), 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk("val.kind", 64'(mismatch_kind_o), 1);
      chk("val.idx", 64'(mismatch_idx_o), 1);
      chk("val.count", 64'(compared_count_o), 1);

      // Copy 1 longer than copy 2.
      do_reset();
      for (int i = 1; i <= 3; i++) cycle(1, 64'(i), 1, 64'(i), 1, 1);
      cycle(1, 64'd4, 0, 0, 1, 1);
      fin_r = 1;
      wait_done(10);
      chk("len.kind", 64'(mismatch_kind_o), 2);
      chk("len.idx", 64'(mismatch_idx_o), 3);

      // Copy 2 stalled while copy 1 overfills.
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1, 64'(i), 1, 64'(i), 1, 0);
      chk("ovf.kind", 64'(mismatch_kind_o), 3);
      chk("ovf.idx", 64'(mismatch_idx_o), 0);
      chk("ovf.done", 64'(done_o), 1);

      // Full buffer with push and compare-pop every cycle.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 64'(100 + i), 0, 0, 1, 0);
      cycle(0, 0, 1, 64'd100, 1, 1);
      for (int i = 0; i < 20; i++) cycle(1, 64'(108 + i), 1, 64'(101 + i), 1, 1);
      chk("full.count", 64'(compared_count_o), 20);
      chk("full.kind", 64'(mismatch_kind_o), 0);

      // Reset while draining with entries pending, then a fresh passing run.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 64'(200 + i), 0, 0, 1, 0);
      fin_r = 1;
      cycle(1, 64'd203, 1, 64'd200, 1, 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk("drain.count", 64'(compared_count_o), 1);
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 64'(300 + i), 1, 64'(300 + i), 1, 1);
      fin_r = 1;
      wait_done(10);
      chk("fresh.mm", 64'(mismatch_o), 0);
      chk("fresh.count", 64'(compared_count_o), 5);

      // Randomized runs.
      for (int run = 0; run < 40; run++) begin
         int len, i1, i2, mode;
         do_reset();
         len  = int'($urandom_range(0, 20));
         mode = int'($urandom_range(0, 2));
         words.delete();
         for (int k = 0; k < len; k++) words.push_back({$urandom, $urandom});
         i1 = 0; i2 = 0;
         for (int cyc = 0; cyc < 80 && m_ph != M_DONE; cyc++) begin
            bit v1, v2, e1, e2;
            logic [63:0] d1, d2;
            v1 = (i1 < len) && ($urandom % 4 != 0);
            v2 = (i2 < len) && ($urandom % 4 != 0);
            e1 = ($urandom % 8 != 0);
            e2 = (mode == 2 && cyc < 12) ? 1'b0 : ($urandom % 8 != 0);
            d1 = v1 ? words[i1] : 64'($urandom);
            d2 = v2 ? words[i2] : 64'($urandom);
            if (v2 && mode == 1 && $urandom % 30 == 0) d2 = d2 ^ (64'd1 << $urandom_range(0, 63));
            if ((i1 >= len && i2 >= len) || cyc > 60) fin_r = 1;
            if (v1 && e1 && m_ph == M_RUN) i1++;
            if (v2 && e2 && m_ph == M_RUN) i2++;
            cycle(v1, d1, v2, d2, e1, e2);
         end
         fin_r = 1;
         wait_done(40);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/obs_trace_compare.md
# obs_trace_compare

Relational-verification checker placed downstream of the dual-copy run controller. It captures observation events (fetch PCs, memory addresses, branch outcomes packed into one word) from two CPU copies running the same program with different secrets. It compares the two traces in order and reports the first divergence. Once the controller's `finished` is seen and both traces have drained, it raises `done_o` with a pass/fail verdict that the contract-synthesis flow reads back.

## Interface
- `DATA_W`, 64, width of one observation word
- `DEPTH`, 8, per-copy buffer depth; power of two, ≥2
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `enable_1_i`  in  1  copy-1 fetch enable from the run controller
- `enable_2_i`  in  1  copy-2 fetch enable from the run controller
- `finished_i`  in  1  run-complete flag from the run controller; sticky upstream
- `obs_1_valid_i`  in  1  copy-1 observation present this cycle
- `obs_1_data_i`  in  DATA_W  copy-1 observation word
- `obs_2_valid_i`  in  1  copy-2 observation present this cycle
- `obs_2_data_i`  in  DATA_W  copy-2 observation word
- `done_o`  out  1  verdict final; sticky until reset
- `mismatch_o`  out  1  traces differ (value or length); valid when `done_o`
- `mismatch_kind_o`  out  2  0 none, 1 value, 2 length, 3 overflow
- `mismatch_idx_o`  out  32  index (0-based) of first differing pair, or pairs compared at length mismatch/overflow
- `compared_count_o`  out  32  pairs compared so far; saturates at 0xFFFF_FFFF

## Operation
- Push k: `obs_k_valid_i && enable_k_i && state==RUN`. Observations while enable low, or outside RUN, are dropped.
- Compare: when both buffers are non-empty and state ∈ {RUN, DRAIN}, pop one entry from each and compare the full word. One pair per cycle.
  - Equal: `compared_count_o`++.
  - Differ: latch idx=count, kind=1, and go to DONE.
- FSM states RUN, DRAIN, DONE. Reset state is RUN.
  - RUN→DRAIN when `finished_i`=1 and there is no mismatch or overflow that cycle.
  - RUN→DONE on value mismatch or overflow.
  - DRAIN→DONE on value mismatch, or when either buffer is empty at the clock edge with no compare possible.
    - Both empty: pass, kind=0.
    - Exactly one non-empty: kind=2, idx=count.
  - DONE is absorbing until reset.
- Overflow: a push to a full buffer without a same-cycle pop of that buffer. Sets kind=3, idx=count, and goes to DONE. The dropped word is not stored.
- Priority in one cycle: value mismatch > overflow > finished.
- `mismatch_o` = (kind≠0). All verdict fields freeze in DONE.

## Timing
- Reset values: `done_o`=0, `mismatch_o`=0, `mismatch_kind_o`=0, `mismatch_idx_o`=0, `compared_count_o`=0; buffers empty; state RUN.
- Reset mid-run clears all state asynchronously. Outputs return to reset values without waiting for a clock.
- Buffers are registered with no bypass. A word pushed at edge N is compared at edge N+1 at the earliest.
- Verdict registers and `done_o` update on the same edge as the deciding compare or drain check, so they are visible in the cycle after it.
- Push-while-full with a same-cycle pop is legal: occupancy is unchanged and there is no overflow.
- Pointers are log2(DEPTH) bits plus a wrap bit. Full = equal index with differing wrap bit.
- The controller updates on the falling edge. `finished_i` and the enables are therefore stable at the rising edge, and no synchroniser is used.
- Minimum pass latency after the last push: 1 cycle to compare, 1 cycle to detect empty in DRAIN, 1 cycle to see `done_o`.

## Structure
- Shared package `obs_cmp_pkg` holds:
  - `state_e` {RUN, DRAIN, DONE}
  - `mismatch_kind_e` {NONE, VALUE, LENGTH, OVERFLOW}
  - the width constant 32 for the counters
- Sub-module `obs_fifo` (parameters `DATA_W`, `DEPTH`; ports push, data, pop, rdata, empty, full) is instantiated once per copy.
- The top level contains the FSM, comparator, counters and verdict registers.

## Test plan
- Identical streams 0x10,0x20,0x30 on both copies, then `finished_i` → `done_o`=1, `mismatch_o`=0, `compared_count_o`=3.
- Copy 2 sends 0x10,0x24,0x30 → kind=1, idx=1, `done_o` one cycle after the second compare. The third pair is never counted.
- Copy 1 sends 4 words, copy 2 sends 3, then `finished_i` → kind=2, idx=3, `done_o`=1 after drain.
- Copy 2 enable low for 9 cycles while copy 1 pushes every cycle with DEPTH=8 → kind=3, idx=0 on the 9th push.
- Buffer full with a simultaneous push and compare-pop for 20 cycles → no overflow, `compared_count_o` increments each cycle.
- Assert `rst_ni`=0 in DRAIN with 3 entries pending → all outputs 0 immediately. After release, a fresh matching run passes.
